// File: rtl/clkdiv_pkg.sv
// Shared types and helpers for the multi-channel clock divider.
package clkdiv_pkg;

  // Widest counter any build may use. Half-periods are held zero-extended to this width.
  localparam int unsigned CNT_W_MAX = 32;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } ch_state_e;

  typedef struct packed {
    logic [CNT_W_MAX-1:0] active;
    logic [CNT_W_MAX-1:0] shadow;
    logic                 pending;
  } ch_cfg_t;

  function automatic int unsigned CeilLog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(n)) r++;
    return (r == 0) ? 1 : r;
  endfunction

  // Reset half-period in base clocks. Never 0, so every channel can wrap.
  function automatic int unsigned CountValue(input int unsigned base_clk,
                                             input int unsigned target);
    int unsigned h;
    if (target == 0) return 1;
    h = base_clk / (2 * target);
    return (h == 0) ? 1 : h;
  endfunction

endpackage

// File: rtl/clkdiv_channel.sv
// One divider channel: counter, active/shadow half-period, square wave and tick.
// Sync restart logic is only built when CLKDIV_SYNC_EN is defined.
module clkdiv_channel
  import clkdiv_pkg::*;
#(
  parameter int unsigned          CNT_W    = 24,
  parameter logic [CNT_W_MAX-1:0] RST_HALF = CNT_W_MAX'(1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  input  logic             wr_i,
  input  logic [CNT_W-1:0] half_i,
  input  logic             sync_i,
  output logic             clk_out_o,
  output logic             tick_o,
  output logic             pending_o,
  output logic [CNT_W-1:0] count_o
);

  ch_state_e            state;
  ch_cfg_t              cfg_q, cfg_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 clk_q, clk_d;
  logic                 tick_q, tick_d;
  logic [CNT_W_MAX-1:0] half_w;
  logic                 wrap;

  assign state = en_i ? RUN : IDLE;

  always_comb begin
    half_w = CNT_W_MAX'(half_i);
    if (half_i == '0) half_w = CNT_W_MAX'(1);
    wrap   = (state == RUN) && (CNT_W_MAX'(cnt_q) == (cfg_q.active - CNT_W_MAX'(1)));

    cfg_d  = cfg_q;
    cnt_d  = cnt_q;
    clk_d  = clk_q;
    tick_d = 1'b0;

    if (wrap) begin
      cnt_d  = '0;
      clk_d  = ~clk_q;
      tick_d = 1'b1;
      if (cfg_q.pending) begin
        cfg_d.active  = cfg_q.shadow;
        cfg_d.pending = 1'b0;
      end
    end else if (state == RUN) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    // A write landing on the wrap cycle bypasses the shadow stage.
    if (wr_i) begin
      cfg_d.shadow = half_w;
      if (wrap) begin
        cfg_d.active  = half_w;
        cfg_d.pending = 1'b0;
      end else begin
        cfg_d.pending = 1'b1;
      end
    end

`ifdef CLKDIV_SYNC_EN
    if (sync_i) begin
      cnt_d         = '0;
      clk_d         = 1'b0;
      tick_d        = 1'b0;
      cfg_d.pending = 1'b0;
      if (wr_i)               cfg_d.active = half_w;
      else if (cfg_q.pending) cfg_d.active = cfg_q.shadow;
    end
`endif
  end

`ifndef CLKDIV_SYNC_EN
  logic sync_unused;
  assign sync_unused = sync_i;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cfg_q.active  <= RST_HALF;
      cfg_q.shadow  <= RST_HALF;
      cfg_q.pending <= 1'b0;
      cnt_q         <= '0;
      clk_q         <= 1'b0;
      tick_q        <= 1'b0;
    end else begin
      cfg_q  <= cfg_d;
      cnt_q  <= cnt_d;
      clk_q  <= clk_d;
      tick_q <= tick_d;
    end
  end

  assign clk_out_o = clk_q;
  assign tick_o    = tick_q;
  assign pending_o = cfg_q.pending;
  assign count_o   = cnt_q;

endmodule

// File: rtl/multi_channel_clk_divider.sv
// N-channel programmable divider: config decode, ack/err pulses, per-channel fan-out.
// Define CLKDIV_SYNC_EN to enable the global sync phase restart.
module multi_channel_clk_divider
  import clkdiv_pkg::*;
#(
  parameter int unsigned NUM_CH           = 4,
  parameter int unsigned BASE_CLK         = 50000000,
  parameter int unsigned TARGET_FREQUENCY = 100000,
  parameter int unsigned DEFAULT_HALF     = CountValue(BASE_CLK, TARGET_FREQUENCY),
  parameter int unsigned CNT_W            = 24,
  parameter int unsigned CH_W             = CeilLog2(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       enable,
  input  logic                    cfg_wr,
  input  logic [CH_W-1:0]         cfg_ch,
  input  logic [CNT_W-1:0]        cfg_half,
  input  logic                    sync,
  output logic                    cfg_ack,
  output logic                    cfg_err,
  output logic [NUM_CH-1:0]       clk_out,
  output logic [NUM_CH-1:0]       tick,
  output logic [NUM_CH-1:0]       pending,
  output logic [NUM_CH*CNT_W-1:0] count_out
);

  localparam logic [CNT_W_MAX-1:0] RST_HALF =
    (DEFAULT_HALF == 0) ? CNT_W_MAX'(1) : CNT_W_MAX'(DEFAULT_HALF);

  logic              ch_valid;
  logic [NUM_CH-1:0] wr_ch;
  logic              ack_q, ack_d;
  logic              err_q, err_d;

  // Channel selects past NUM_CH exist whenever NUM_CH is not a power of two.
  assign ch_valid = (32'(cfg_ch) < NUM_CH);

  always_comb begin
    ack_d = cfg_wr & ch_valid;
    err_d = cfg_wr & ~ch_valid;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      ack_q <= ack_d;
      err_q <= err_d;
    end
  end

  assign cfg_ack = ack_q;
  assign cfg_err = err_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign wr_ch[i] = cfg_wr && (32'(cfg_ch) == 32'(i));

    clkdiv_channel #(
      .CNT_W    (CNT_W),
      .RST_HALF (RST_HALF)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .en_i      (enable[i]),
      .wr_i      (wr_ch[i]),
      .half_i    (cfg_half),
      .sync_i    (sync),
      .clk_out_o (clk_out[i]),
      .tick_o    (tick[i]),
      .pending_o (pending[i]),
      .count_o   (count_out[i*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_multi_channel_clk_divider.sv
// Directed bench: expectations are queued when stimulus is driven and popped at sample time.
module tb_multi_channel_clk_divider;
  localparam int CW = 24;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [3:0]      enable = '0;
  logic            cfg_wr = 1'b0;
  logic [1:0]      cfg_ch = '0;
  logic [CW-1:0]   cfg_half = '0;
  logic            sync = 1'b0;
  logic            cfg_ack, cfg_err;
  logic [3:0]      clk_out, tick, pending;
  logic [4*CW-1:0] count_out;

  logic [4:0]      en5 = '0;
  logic            wr5 = 1'b0;
  logic [2:0]      ch5 = '0;
  logic [CW-1:0]   half5 = '0;
  logic            ack5, err5;
  logic [4:0]      clk_out5, tick5, pend5;
  logic [5*CW-1:0] cnt5;

  multi_channel_clk_divider #(.NUM_CH(4), .BASE_CLK(1000), .TARGET_FREQUENCY(100), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .enable(enable), .cfg_wr(cfg_wr), .cfg_ch(cfg_ch),
    .cfg_half(cfg_half), .sync(sync), .cfg_ack(cfg_ack), .cfg_err(cfg_err),
    .clk_out(clk_out), .tick(tick), .pending(pending), .count_out(count_out));

  multi_channel_clk_divider #(.NUM_CH(5), .BASE_CLK(1000), .TARGET_FREQUENCY(100), .CNT_W(CW)) dut5 (
    .clk(clk), .reset(reset), .enable(en5), .cfg_wr(wr5), .cfg_ch(ch5),
    .cfg_half(half5), .sync(1'b0), .cfg_ack(ack5), .cfg_err(err5),
    .clk_out(clk_out5), .tick(tick5), .pending(pend5), .count_out(cnt5));

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] v;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   n = 0;

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.v   = v;
    sb.push_back(e);
  endtask

  task automatic chk(input logic [31:0] obs);
    exp_t e;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $error("FAIL scoreboard_underflow observed=%0h", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.v) else begin
        bad++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.v);
      end
    end
  endtask

  function automatic logic [31:0] cnt(input int i);
    return 32'(count_out[i*CW +: CW]);
  endfunction

  // Advance to 1 time unit after enabled edge number k since the last reset release.
  task automatic go(input int k);
    while (n < k) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  initial begin
    // reset state
    #2;
    push("rst_count", 1); push("rst_clk", 0); push("rst_tick", 0);
    push("rst_pend", 0); push("rst_ack", 0); push("rst_err", 0);
    chk(32'(count_out == '0)); chk(clk_out); chk(tick); chk(pending); chk(cfg_ack); chk(cfg_err);
    @(posedge clk); #1;
    enable = 4'hf;
    reset = 1'b0;

    // default half of 5: first toggle on edge 5, period 10
    push("e4_cnt0", 4); push("e4_tick", 0); push("e4_clk", 0);
    go(4); chk(cnt(0)); chk(tick); chk(clk_out);
    push("e5_tick", 4'hf); push("e5_clk", 4'hf); push("e5_cnt0", 0); push("e5_cnt3", 0);
    go(5); chk(tick); chk(clk_out); chk(cnt(0)); chk(cnt(3));
    push("e6_tick", 0); push("e6_cnt1", 1);
    go(6); chk(tick); chk(cnt(1));
    push("e10_tick", 4'hf); push("e10_clk", 0);
    go(10); chk(tick); chk(clk_out);

    // shadow write on ch1 mid-half
    push("e11_cnt1", 1);
    go(11); chk(cnt(1));
    cfg_wr = 1'b1; cfg_ch = 2'd1; cfg_half = 24'd2;
    push("wr1_ack", 1); push("wr1_err", 0); push("wr1_pend", 4'b0010);
    go(12); chk(cfg_ack); chk(cfg_err); chk(pending);
    cfg_wr = 1'b0;
    push("e13_ack", 0); push("e13_pend", 4'b0010); push("e13_cnt1", 3);
    go(13); chk(cfg_ack); chk(pending); chk(cnt(1));
    push("e15_tick", 4'hf); push("e15_pend", 0); push("e15_clk", 4'hf);
    go(15); chk(tick); chk(pending); chk(clk_out);
    push("e16_tick", 0);
    go(16); chk(tick);
    push("e17_tick", 4'b0010); push("e17_clk", 4'b1101); push("e17_cnt1", 0);
    go(17); chk(tick); chk(clk_out); chk(cnt(1));
    push("e19_tick", 4'b0010); push("e19_cnt2", 4);
    go(19); chk(tick); chk(cnt(2));

    // write on ch2 in its wrap cycle is forwarded
    cfg_wr = 1'b1; cfg_ch = 2'd2; cfg_half = 24'd3;
    push("fwd_tick", 4'b1101); push("fwd_pend", 0); push("fwd_ack", 1); push("fwd_clk", 4'b0010);
    go(20); chk(tick); chk(pending); chk(cfg_ack); chk(clk_out);
    cfg_wr = 1'b0;
    push("e21_tick", 4'b0010); push("e21_pend", 0);
    go(21); chk(tick); chk(pending);
    push("e22_tick", 0);
    go(22); chk(tick);
    push("e23_tick", 4'b0110); push("e23_cnt0", 3);
    go(23); chk(tick); chk(cnt(0));

    // ch0 idle for 7 edges
    enable = 4'b1110;
    push("idle_cnt0", 3); push("idle_tick", 4'b0010); push("idle_cnt3", 2); push("idle_clk0", 0);
    go(27); chk(cnt(0)); chk(tick); chk(cnt(3)); chk(32'(clk_out[0]));
    push("e30_cnt0", 3); push("e30_tick", 4'b1000);
    go(30); chk(cnt(0)); chk(tick);
    enable = 4'hf;
    push("e31_cnt0", 4); push("e31_tick0", 0);
    go(31); chk(cnt(0)); chk(32'(tick[0]));
    push("e32_tick", 4'b0101); push("e32_cnt0", 0); push("e32_clk0", 1);
    go(32); chk(tick); chk(cnt(0)); chk(32'(clk_out[0]));

    // half=0 on ch3 behaves as half=1
    cfg_wr = 1'b1; cfg_ch = 2'd3; cfg_half = 24'd0;
    push("h0_pend", 4'b1000); push("h0_ack", 1);
    go(33); chk(pending); chk(cfg_ack);
    cfg_wr = 1'b0;
    push("e35_tick3", 1); push("e35_pend", 0);
    go(35); chk(32'(tick[3])); chk(pending);

    // invalid channel on the 5-channel build
    wr5 = 1'b1; ch5 = 3'd5; half5 = 24'd7;
    push("e36_tick3", 1); push("e36_clk3", 0); push("e36_cnt3", 0);
    push("inv_err", 1); push("inv_ack", 0); push("inv_pend", 0);
    go(36); chk(32'(tick[3])); chk(32'(clk_out[3])); chk(cnt(3));
    chk(err5); chk(ack5); chk(pend5);
    ch5 = 3'd4;
    push("e37_tick3", 1); push("e37_clk3", 1); push("v5_ack", 1); push("v5_err", 0); push("v5_pend", 5'b10000);
    go(37); chk(32'(tick[3])); chk(32'(clk_out[3])); chk(ack5); chk(err5); chk(pend5);
    wr5 = 1'b0;

    // sync pulse: restart when compiled in, ignored otherwise
    sync = 1'b1;
`ifdef CLKDIV_SYNC_EN
    push("sync_cnt0", 0); push("sync_cnt2", 0); push("sync_clk", 0); push("sync_tick", 0);
    go(38); chk(cnt(0)); chk(cnt(2)); chk(clk_out); chk(tick);
    sync = 1'b0;
    push("sync_e39_cnt0", 1); push("sync_e39_cnt2", 1);
    go(39); chk(cnt(0)); chk(cnt(2));
`else
    push("nosync_cnt0", 1); push("nosync_tick", 4'b1100);
    go(38); chk(cnt(0)); chk(tick);
    sync = 1'b0;
    push("nosync_e39_cnt0", 2);
    go(39); chk(cnt(0));
`endif

    // async reset mid-cycle clears pending state with no clock edge
    cfg_wr = 1'b1; cfg_ch = 2'd0; cfg_half = 24'd9;
    push("e40_pend", 4'b0001);
    go(40); chk(pending);
    cfg_wr = 1'b0;
    #2 reset = 1'b1;
    #1;
    push("arst_count", 1); push("arst_clk", 0); push("arst_tick", 0); push("arst_pend", 0); push("arst_pend5", 0);
    chk(32'(count_out == '0)); chk(clk_out); chk(tick); chk(pending); chk(pend5);
    reset = 1'b0;
    n = 0;
    push("rr_e4_tick", 0); push("rr_e4_cnt0", 4);
    go(4); chk(tick); chk(cnt(0));
    push("rr_e5_tick", 4'hf); push("rr_e5_clk", 4'hf);
    go(5); chk(tick); chk(clk_out);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
